// File: rtl/hubris_pkg.sv
// Shared types for the Hubris pipeline control block: forwarding selects,
// halt FSM states and the in-flight instruction tracker entries.
package hubris_pkg;

    localparam logic [1:0] FWD_SRC_IDEX  = 2'b00;
    localparam logic [1:0] FWD_SRC_EXMEM = 2'b01;
    localparam logic [1:0] FWD_SRC_WB    = 2'b10;

    // Register indices are carried at a fixed maximum width and zero-extended.
    localparam int unsigned MAX_REG_ADDR_W = 8;
    typedef logic [MAX_REG_ADDR_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        HALT_RUN,
        HALT_DRAIN,
        HALT_HALTED
    } halt_state_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
    } producer_t;

    typedef struct packed {
        producer_t dst;
        logic      load;
        logic      halt;
    } stage_entry_t;

    function automatic logic src_match(input producer_t p, input reg_idx_t src, input logic used);
        return p.valid && p.we && (p.rd == src) && (src != '0) && used;
    endfunction

endpackage

// File: rtl/hubris_stage_tracker.sv
// Three-stage shift register of in-flight destinations (EX, MEM, WB) plus the
// source comparators for both the ID instruction and the EX instruction.
module hubris_stage_tracker
    import hubris_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_load,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  id_is_halt,
    output logic [2:0]            id_rs1_hit,
    output logic [2:0]            id_rs2_hit,
    output logic [1:0]            ex_rs1_hit,
    output logic [1:0]            ex_rs2_hit,
    output logic                  ex_load_valid,
    output logic                  ex_halt_valid
);

    stage_entry_t ex_q;
    producer_t    mem_q;
    producer_t    wb_q;
    reg_idx_t     ex_rs1_q;
    reg_idx_t     ex_rs2_q;
    logic         ex_rs1_used_q;
    logic         ex_rs2_used_q;

    reg_idx_t     id_rs1_x;
    reg_idx_t     id_rs2_x;
    stage_entry_t id_entry;

    assign id_rs1_x = reg_idx_t'(id_rs1);
    assign id_rs2_x = reg_idx_t'(id_rs2);
    assign id_entry = '{dst: '{valid: 1'b1, rd: reg_idx_t'(id_rd), we: id_rd_we},
                        load: id_is_load, halt: id_is_halt};

    // NOTE: non-blocking assignments make every stage shift from its pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q.dst;
            if (ex_load) begin
                ex_q          <= id_entry;
                ex_rs1_q      <= id_rs1_x;
                ex_rs2_q      <= id_rs2_x;
                ex_rs1_used_q <= id_rs1_used;
                ex_rs2_used_q <= id_rs2_used;
            end else begin
                ex_q          <= '0;
                ex_rs1_used_q <= 1'b0;
                ex_rs2_used_q <= 1'b0;
            end
        end
    end

    // Bit 0 = EX, 1 = MEM, 2 = WB producer for the ID sources.
    assign id_rs1_hit = {src_match(wb_q, id_rs1_x, id_rs1_used),
                         src_match(mem_q, id_rs1_x, id_rs1_used),
                         src_match(ex_q.dst, id_rs1_x, id_rs1_used)};
    assign id_rs2_hit = {src_match(wb_q, id_rs2_x, id_rs2_used),
                         src_match(mem_q, id_rs2_x, id_rs2_used),
                         src_match(ex_q.dst, id_rs2_x, id_rs2_used)};

    // Bit 0 = MEM, 1 = WB producer for the EX sources.
    assign ex_rs1_hit = {src_match(wb_q, ex_rs1_q, ex_rs1_used_q),
                         src_match(mem_q, ex_rs1_q, ex_rs1_used_q)};
    assign ex_rs2_hit = {src_match(wb_q, ex_rs2_q, ex_rs2_used_q),
                         src_match(mem_q, ex_rs2_q, ex_rs2_used_q)};

    assign ex_load_valid = ex_q.dst.valid && ex_q.load;
    assign ex_halt_valid = ex_q.dst.valid && ex_q.halt;

endmodule

// File: rtl/hubris_hazard_unit.sv
// Hubris 5-stage pipeline control: forwarding selects, WB bypass, load-use or
// full interlock stalls, branch flush and the drain-then-halt sequence.
module hubris_hazard_unit
    import hubris_pkg::*;
#(
    parameter int unsigned REG_ADDR_W       = 5,
    parameter bit          FWD_EN           = 1'b1,
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned DRAIN_CYCLES     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  id_is_halt,
    input  logic                  ex_branch_taken,
    output logic                  stall_if,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic [1:0]            ex_fwd_rs1,
    output logic [1:0]            ex_fwd_rs2,
    output logic                  id_wb_byp_rs1,
    output logic                  id_wb_byp_rs2,
    output logic                  halt
);

    localparam int unsigned       DCNT_W     = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [1:0]        LU_LOAD    = 2'(LOAD_USE_BUBBLES - 1);

    logic [2:0]        rs1_hit;
    logic [2:0]        rs2_hit;
    logic [1:0]        ex1_hit;
    logic [1:0]        ex2_hit;
    logic              ex_load_valid;
    logic              ex_halt_valid;
    logic              ex_load;
    logic              load_use;
    logic              interlock;
    logic              stall_req;
    logic [1:0]        lu_cnt_q;
    logic [DCNT_W-1:0] drain_cnt_q;
    halt_state_e       state_q;

    hubris_stage_tracker #(.REG_ADDR_W(REG_ADDR_W)) u_tracker (
        .clk           (clk),
        .reset         (reset),
        .ex_load       (ex_load),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .id_rd         (id_rd),
        .id_rd_we      (id_rd_we),
        .id_is_load    (id_is_load),
        .id_is_halt    (id_is_halt),
        .id_rs1_hit    (rs1_hit),
        .id_rs2_hit    (rs2_hit),
        .ex_rs1_hit    (ex1_hit),
        .ex_rs2_hit    (ex2_hit),
        .ex_load_valid (ex_load_valid),
        .ex_halt_valid (ex_halt_valid)
    );

    assign load_use  = FWD_EN && id_valid && ex_load_valid && (rs1_hit[0] || rs2_hit[0]);
    assign interlock = !FWD_EN && id_valid && ((|rs1_hit) || (|rs2_hit));
    assign stall_req = load_use || interlock || (lu_cnt_q != 2'd0);

    // A flushed or bubbled ID slot never enters EX, so a discarded halt is lost here.
    assign ex_load = id_valid && !bubble_ex && !flush_id;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (state_q != HALT_RUN) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end else if (ex_branch_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (stall_req) begin
            stall_if  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    always_comb begin
        ex_fwd_rs1 = FWD_SRC_IDEX;
        ex_fwd_rs2 = FWD_SRC_IDEX;
        if (FWD_EN) begin
            if (ex1_hit[0])      ex_fwd_rs1 = FWD_SRC_EXMEM;
            else if (ex1_hit[1]) ex_fwd_rs1 = FWD_SRC_WB;
            if (ex2_hit[0])      ex_fwd_rs2 = FWD_SRC_EXMEM;
            else if (ex2_hit[1]) ex_fwd_rs2 = FWD_SRC_WB;
        end
    end

    assign id_wb_byp_rs1 = FWD_EN && rs1_hit[2];
    assign id_wb_byp_rs2 = FWD_EN && rs2_hit[2];
    assign halt          = (state_q == HALT_HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HALT_RUN;
            drain_cnt_q <= '0;
            lu_cnt_q    <= 2'd0;
        end else begin
            // The detection cycle is the first bubble; the counter covers the rest.
            if (ex_branch_taken)        lu_cnt_q <= 2'd0;
            else if (lu_cnt_q != 2'd0)  lu_cnt_q <= lu_cnt_q - 2'd1;
            else if (load_use)          lu_cnt_q <= LU_LOAD;

            unique case (state_q)
                HALT_RUN: begin
                    if (ex_halt_valid && !ex_branch_taken) begin
                        if (DRAIN_CYCLES <= 1) begin
                            state_q <= HALT_HALTED;
                        end else begin
                            state_q     <= HALT_DRAIN;
                            drain_cnt_q <= DRAIN_LOAD;
                        end
                    end
                end
                HALT_DRAIN: begin
                    if (drain_cnt_q <= DCNT_W'(1)) state_q     <= HALT_HALTED;
                    else                           drain_cnt_q <= drain_cnt_q - DCNT_W'(1);
                end
                HALT_HALTED: state_q <= HALT_HALTED;
                default:     state_q <= HALT_RUN;
            endcase
        end
    end

endmodule
